// File: rtl/hazard_sb_ctrl.sv
// Pipeline hazard controller: operand forwarding select, load-use and multi-cycle scoreboard
// stalls, branch redirect/flush, and saturating stall/flush performance counters.
module hazard_sb_ctrl #(
    parameter int NUM_RPORTS    = 3,
    parameter int NUM_FWD_STG   = 4,
    parameter int NUM_PIPE_REGS = 6,
    parameter int PC_W          = 32,
    parameter int CNT_W         = 32,
    localparam int FW           = $clog2(NUM_FWD_STG + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_resetn,
    input  logic                      i_ex_out_valid,
    input  logic [NUM_RPORTS-1:0]     i_id_ren,
    input  logic [5*NUM_RPORTS-1:0]   i_id_rs,
    input  logic [NUM_FWD_STG-1:0]    i_stg_wen,
    input  logic [5*NUM_FWD_STG-1:0]  i_stg_rd,
    input  logic [NUM_FWD_STG-1:0]    i_stg_rdy,
    input  logic                      i_mc_issue,
    input  logic [4:0]                i_mc_rd,
    input  logic                      i_mc_done,
    input  logic [4:0]                i_mc_done_rd,
    input  logic                      i_id_is_mc,
    input  logic [PC_W-1:0]           i_id_pc,
    input  logic                      i_id_is_branch,
    input  logic                      i_id_branch_bp,
    input  logic [PC_W-1:0]           i_ex_pc,
    input  logic                      i_ex_branch,
    input  logic                      i_ex_branch_bp,
    input  logic [PC_W-1:0]           i_ex_pc_branch,
    output logic [FW*NUM_RPORTS-1:0]  o_fwd_sel,
    output logic                      o_pc_wen,
    output logic                      o_redirect,
    output logic [PC_W-1:0]           o_redirect_pc,
    output logic [NUM_PIPE_REGS-1:0]  o_pipe_wen,
    output logic [NUM_PIPE_REGS-1:0]  o_pipe_flush,
    output logic                      o_id_ex_bp_flush,
    output logic [CNT_W-1:0]          o_stall_cnt,
    output logic [CNT_W-1:0]          o_flush_cnt
);

    typedef enum logic [2:0] {
        C_EX_BUSY,
        C_BP_FAULT,
        C_STALL,
        C_NOT_BR,
        C_RUN
    } ctrl_case_e;

    logic [31:0]            r_sb_busy;
    logic [CNT_W-1:0]       r_stall_cnt;
    logic [CNT_W-1:0]       r_flush_cnt;

    logic [FW*NUM_RPORTS-1:0] w_fwd_sel;
    logic                   w_raw_stall;
    logic                   w_sb_stall;
    logic                   w_mc_busy;
    logic                   w_bp_fault;
    logic                   w_not_branch;
    ctrl_case_e             w_case;
    logic [31:0]            w_sb_next;

    assign w_mc_busy = |r_sb_busy;

    // Youngest matching stage wins; a port with a forwarding hit never waits on the scoreboard.
    always_comb begin : p_fwd
        logic w_hit;
        // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
        w_fwd_sel   = '0;
        w_raw_stall = 1'b0;
        w_sb_stall  = i_id_is_mc & w_mc_busy;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            w_hit = 1'b0;
            if (i_id_ren[p] && (i_id_rs[5*p +: 5] != 5'd0)) begin
                for (int i = 0; i < NUM_FWD_STG; i++) begin
                    if (!w_hit && i_stg_wen[i] && (i_stg_rd[5*i +: 5] == i_id_rs[5*p +: 5])) begin
                        w_hit                = 1'b1;
                        w_fwd_sel[FW*p +: FW] = FW'(i + 1);
                        if (!i_stg_rdy[i]) begin
                            w_raw_stall = 1'b1;
                        end
                    end
                end
                if (!w_hit && r_sb_busy[i_id_rs[5*p +: 5]]) begin
                    w_sb_stall = 1'b1;
                end
            end
        end
    end

    assign w_bp_fault   = (i_ex_branch != i_ex_branch_bp) |
                          (i_ex_branch & (i_ex_pc_branch != i_id_pc));
    assign w_not_branch = ~i_id_is_branch & i_id_branch_bp;

    always_comb begin
        if (!i_ex_out_valid) begin
            w_case = C_EX_BUSY;
        end else if (w_bp_fault) begin
            w_case = C_BP_FAULT;
        end else if (w_raw_stall || w_sb_stall) begin
            w_case = C_STALL;
        end else if (w_not_branch) begin
            w_case = C_NOT_BR;
        end else begin
            w_case = C_RUN;
        end
    end

    always_comb begin
        o_fwd_sel        = w_fwd_sel;
        o_pc_wen         = 1'b1;
        o_redirect       = 1'b0;
        o_redirect_pc    = '0;
        o_pipe_wen       = '1;
        o_pipe_flush     = '0;
        o_id_ex_bp_flush = 1'b0;
        if (!i_resetn) begin
            o_fwd_sel    = '0;
            o_pc_wen     = 1'b0;
            o_pipe_wen   = '0;
            o_pipe_flush = '1;
        end else begin
            unique case (w_case)
                C_EX_BUSY: begin
                    o_pipe_wen[2:0] = 3'b000;
                    o_pipe_flush[3] = 1'b1;
                    o_pc_wen        = 1'b0;
                end
                C_BP_FAULT: begin
                    o_redirect        = 1'b1;
                    o_redirect_pc     = i_ex_branch ? i_ex_pc_branch : i_ex_pc + PC_W'(4);
                    o_pipe_flush[2:0] = 3'b111;
                end
                C_STALL: begin
                    o_pipe_wen[1:0] = 2'b00;
                    o_pipe_flush[2] = 1'b1;
                    o_pc_wen        = 1'b0;
                end
                C_NOT_BR: begin
                    o_redirect        = 1'b1;
                    o_redirect_pc     = i_id_pc + PC_W'(4);
                    o_pipe_flush[1:0] = 2'b11;
                    o_id_ex_bp_flush  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A multi-cycle op killed in EX (busy hold or mispredict) never reaches the scoreboard.
    always_comb begin
        w_sb_next = r_sb_busy;
        if (i_mc_done) begin
            w_sb_next[i_mc_done_rd] = 1'b0;
        end
        // NOTE: set is applied after clear so a same-cycle issue+done on one register leaves it busy.
        if (i_mc_issue && (i_mc_rd != 5'd0) && (w_case != C_EX_BUSY) && (w_case != C_BP_FAULT)) begin
            w_sb_next[i_mc_rd] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments and a synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sb_busy   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_sb_busy <= w_sb_next;
            if (((w_case == C_EX_BUSY) || (w_case == C_STALL)) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (((w_case == C_BP_FAULT) || (w_case == C_NOT_BR)) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_sb_ctrl.sv
// Scoreboard bench for hazard_sb_ctrl: a reference model pushes expected outputs per cycle,
// each scenario task pops and compares them; counters use a narrow width to reach saturation.
module tb_hazard_sb_ctrl;

    localparam int NR = 3;
    localparam int NF = 4;
    localparam int NP = 6;
    localparam int FW = 3;
    localparam int CW = 4;
    localparam int CTL_W = FW*NR + 1 + 1 + 32 + NP + NP + 1;

    typedef struct packed {
        logic                  resetn;
        logic                  ex_out_valid;
        logic [NR-1:0]         ren;
        logic [NR-1:0][4:0]    rs;
        logic [NF-1:0]         wen;
        logic [NF-1:0][4:0]    rd;
        logic [NF-1:0]         rdy;
        logic                  mc_issue;
        logic [4:0]            mc_rd;
        logic                  mc_done;
        logic [4:0]            mc_done_rd;
        logic                  id_is_mc;
        logic [31:0]           id_pc;
        logic                  id_is_branch;
        logic                  id_branch_bp;
        logic [31:0]           ex_pc;
        logic                  ex_branch;
        logic                  ex_branch_bp;
        logic [31:0]           ex_pc_branch;
    } stim_t;

    typedef struct packed {
        logic [CTL_W-1:0] ctl;
        logic [CW-1:0]    sc;
        logic [CW-1:0]    fc;
        logic             chk_cnt;
    } exp_t;

    logic clk;
    stim_t s;
    stim_t d;
    exp_t  q[$];
    int    n_vec;
    int    n_err;

    logic [31:0] m_sb, n_sb;
    logic [CW-1:0] m_sc, n_sc, m_fc, n_fc;
    logic m_known, n_known;

    logic [FW*NR-1:0] o_fwd_sel;
    logic             o_pc_wen;
    logic             o_redirect;
    logic [31:0]      o_redirect_pc;
    logic [NP-1:0]    o_pipe_wen;
    logic [NP-1:0]    o_pipe_flush;
    logic             o_id_ex_bp_flush;
    logic [CW-1:0]    o_stall_cnt;
    logic [CW-1:0]    o_flush_cnt;
    logic [CTL_W-1:0] dut_ctl;

    assign dut_ctl = {o_fwd_sel, o_pc_wen, o_redirect, o_redirect_pc,
                      o_pipe_wen, o_pipe_flush, o_id_ex_bp_flush};

    hazard_sb_ctrl #(.CNT_W(CW)) dut (
        .i_clk            (clk),
        .i_resetn         (d.resetn),
        .i_ex_out_valid   (d.ex_out_valid),
        .i_id_ren         (d.ren),
        .i_id_rs          (d.rs),
        .i_stg_wen        (d.wen),
        .i_stg_rd         (d.rd),
        .i_stg_rdy        (d.rdy),
        .i_mc_issue       (d.mc_issue),
        .i_mc_rd          (d.mc_rd),
        .i_mc_done        (d.mc_done),
        .i_mc_done_rd     (d.mc_done_rd),
        .i_id_is_mc       (d.id_is_mc),
        .i_id_pc          (d.id_pc),
        .i_id_is_branch   (d.id_is_branch),
        .i_id_branch_bp   (d.id_branch_bp),
        .i_ex_pc          (d.ex_pc),
        .i_ex_branch      (d.ex_branch),
        .i_ex_branch_bp   (d.ex_branch_bp),
        .i_ex_pc_branch   (d.ex_pc_branch),
        .o_fwd_sel        (o_fwd_sel),
        .o_pc_wen         (o_pc_wen),
        .o_redirect       (o_redirect),
        .o_redirect_pc    (o_redirect_pc),
        .o_pipe_wen       (o_pipe_wen),
        .o_pipe_flush     (o_pipe_flush),
        .o_id_ex_bp_flush (o_id_ex_bp_flush),
        .o_stall_cnt      (o_stall_cnt),
        .o_flush_cnt      (o_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        s = '0;
        s.resetn = 1'b1;
        s.ex_out_valid = 1'b1;
    endtask

    // Apply s after a falling edge, predict the outputs from the model state, push the prediction.
    task automatic step();
        logic [NR-1:0][FW-1:0] fwd;
        logic raw, sbst, fault, nb, c1, c2, c3, c4, pcw, redir, bpf, rdy_v;
        logic [31:0] rpc;
        logic [NP-1:0] wen, flush;
        exp_t e;
        @(negedge clk);
        m_sb = n_sb; m_sc = n_sc; m_fc = n_fc; m_known = n_known;
        d = s;
        fwd = '0; raw = 1'b0; sbst = d.id_is_mc && (m_sb != 32'd0);
        for (int p = 0; p < NR; p++) begin
            rdy_v = 1'b1;
            if (d.ren[p] && d.rs[p] != 5'd0) begin
                for (int i = NF - 1; i >= 0; i--) begin
                    if (d.wen[i] && d.rd[i] == d.rs[p]) begin
                        fwd[p] = FW'(i + 1);
                        rdy_v  = d.rdy[i];
                    end
                end
                if (fwd[p] != 0 && !rdy_v) raw = 1'b1;
                if (fwd[p] == 0 && m_sb[d.rs[p]]) sbst = 1'b1;
            end
        end
        fault = (d.ex_branch != d.ex_branch_bp) || (d.ex_branch && d.ex_pc_branch != d.id_pc);
        nb = !d.id_is_branch && d.id_branch_bp;
        c1 = !d.ex_out_valid;
        c2 = !c1 && fault;
        c3 = !c1 && !c2 && (raw || sbst);
        c4 = !c1 && !c2 && !c3 && nb;
        redir = 1'b0; rpc = 32'd0; bpf = 1'b0;
        if (!d.resetn) begin
            fwd = '0; pcw = 1'b0; wen = 6'b000000; flush = 6'b111111;
        end else if (c1) begin
            pcw = 1'b0; wen = 6'b111000; flush = 6'b001000;
        end else if (c2) begin
            pcw = 1'b1; wen = 6'b111111; flush = 6'b000111; redir = 1'b1;
            rpc = d.ex_branch ? d.ex_pc_branch : d.ex_pc + 32'd4;
        end else if (c3) begin
            pcw = 1'b0; wen = 6'b111100; flush = 6'b000100;
        end else if (c4) begin
            pcw = 1'b1; wen = 6'b111111; flush = 6'b000011; redir = 1'b1; bpf = 1'b1;
            rpc = d.id_pc + 32'd4;
        end else begin
            pcw = 1'b1; wen = 6'b111111; flush = 6'b000000;
        end
        e.ctl = {fwd, pcw, redir, rpc, wen, flush, bpf};
        e.sc = m_sc; e.fc = m_fc; e.chk_cnt = m_known;
        q.push_back(e);
        if (!d.resetn) begin
            n_sb = 32'd0; n_sc = '0; n_fc = '0; n_known = 1'b1;
        end else begin
            n_sb = m_sb;
            if (d.mc_done) n_sb[d.mc_done_rd] = 1'b0;
            if (d.mc_issue && !c1 && !c2 && d.mc_rd != 5'd0) n_sb[d.mc_rd] = 1'b1;
            n_sc = ((c1 || c3) && m_sc != 4'hF) ? m_sc + 4'd1 : m_sc;
            n_fc = ((c2 || c4) && m_fc != 4'hF) ? m_fc + 4'd1 : m_fc;
        end
        #2;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            clr();
            s.resetn = 1'b0; s.ren = '1; s.rs[0] = 5'd5; s.wen[0] = 1'b1; s.rd[0] = 5'd5;
            s.ex_branch = 1'b1; s.id_branch_bp = 1'b1;
            step();
            e = q.pop_front();
            n_vec++;
            if (dut_ctl !== e.ctl) begin
                n_err++; $display("FAIL reset_%0d ctl act=%h exp=%h", k, dut_ctl, e.ctl);
            end
            if (e.chk_cnt) begin
                n_vec++;
                if ({o_stall_cnt, o_flush_cnt} !== {e.sc, e.fc}) begin
                    n_err++; $display("FAIL reset_%0d cnt act=%h/%h exp=%h/%h", k, o_stall_cnt, o_flush_cnt, e.sc, e.fc);
                end
            end
        end
    endtask

    task automatic test_forwarding();
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            clr();
            case (k)
                0: begin s.wen[0] = 1; s.rd[0] = 5; s.rdy[0] = 0; s.ren[0] = 1; s.rs[0] = 5; end
                1: begin s.wen = 4'b0101; s.rd[0] = 7; s.rd[2] = 7; s.rdy = '1; s.ren[1] = 1; s.rs[1] = 7; end
                2: begin s.wen = 4'b1010; s.rd[1] = 12; s.rd[3] = 12; s.rdy = 4'b1101; s.ren[2] = 1; s.rs[2] = 12; end
                3: begin s.wen[0] = 1; s.rd[0] = 0; s.ren[0] = 1; s.rs[0] = 0; end
                4: begin s.wen[0] = 1; s.rd[0] = 5; s.ren[0] = 0; s.rs[0] = 5; end
                default: begin s.wen[3] = 1; s.rd[3] = 20; s.rdy[3] = 1; s.ren = '1; s.rs[2] = 20; s.rs[0] = 21; end
            endcase
            step();
            e = q.pop_front();
            n_vec++;
            if (dut_ctl !== e.ctl) begin
                n_err++; $display("FAIL fwd_%0d ctl act=%h exp=%h", k, dut_ctl, e.ctl);
            end
            n_vec++;
            if ({o_stall_cnt, o_flush_cnt} !== {e.sc, e.fc}) begin
                n_err++; $display("FAIL fwd_%0d cnt act=%h/%h exp=%h/%h", k, o_stall_cnt, o_flush_cnt, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        for (int k = 0; k < 13; k++) begin
            clr();
            case (k)
                0: begin s.mc_issue = 1; s.mc_rd = 9; end
                1, 2, 4: begin s.ren[0] = 1; s.rs[0] = 9; end
                3: begin s.ren[0] = 1; s.rs[0] = 9; s.mc_done = 1; s.mc_done_rd = 9; end
                5: begin s.mc_issue = 1; s.mc_rd = 3; end
                6, 8, 10: s.id_is_mc = 1;
                7: begin s.mc_issue = 1; s.mc_rd = 3; s.mc_done = 1; s.mc_done_rd = 3; end
                9: begin s.mc_done = 1; s.mc_done_rd = 3; end
                11: begin s.ex_out_valid = 0; s.mc_issue = 1; s.mc_rd = 11; end
                default: begin s.ren[1] = 1; s.rs[1] = 11; s.mc_done = 1; s.mc_done_rd = 14; end
            endcase
            step();
            e = q.pop_front();
            n_vec++;
            if (dut_ctl !== e.ctl) begin
                n_err++; $display("FAIL sb_%0d ctl act=%h exp=%h", k, dut_ctl, e.ctl);
            end
            n_vec++;
            if ({o_stall_cnt, o_flush_cnt} !== {e.sc, e.fc}) begin
                n_err++; $display("FAIL sb_%0d cnt act=%h/%h exp=%h/%h", k, o_stall_cnt, o_flush_cnt, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        for (int k = 0; k < 7; k++) begin
            clr();
            case (k)
                0: begin
                    s.ex_branch = 1; s.ex_branch_bp = 0; s.ex_pc_branch = 32'h1C00_0040; s.ex_pc = 32'h1C00_0000;
                    s.wen[0] = 1; s.rd[0] = 5; s.ren[0] = 1; s.rs[0] = 5;
                end
                1: begin s.id_is_branch = 0; s.id_branch_bp = 1; s.id_pc = 32'h100; end
                2: begin s.ex_branch = 0; s.ex_branch_bp = 1; s.ex_pc = 32'hFFFF_FFFC; end
                3: begin s.ex_branch = 1; s.ex_branch_bp = 1; s.ex_pc_branch = 32'h200; s.id_pc = 32'h200; end
                4: begin s.ex_branch = 1; s.ex_branch_bp = 1; s.ex_pc_branch = 32'h200; s.id_pc = 32'h204; end
                5: begin s.ex_out_valid = 0; s.ex_branch = 1; s.ex_pc_branch = 32'h300; s.id_branch_bp = 1; end
                default: begin
                    s.id_branch_bp = 1; s.id_pc = 32'h400;
                    s.wen[1] = 1; s.rd[1] = 6; s.ren[2] = 1; s.rs[2] = 6;
                end
            endcase
            step();
            e = q.pop_front();
            n_vec++;
            if (dut_ctl !== e.ctl) begin
                n_err++; $display("FAIL br_%0d ctl act=%h exp=%h", k, dut_ctl, e.ctl);
            end
            n_vec++;
            if ({o_stall_cnt, o_flush_cnt} !== {e.sc, e.fc}) begin
                n_err++; $display("FAIL br_%0d cnt act=%h/%h exp=%h/%h", k, o_stall_cnt, o_flush_cnt, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int k = 0; k < 37; k++) begin
            clr();
            if (k == 0 || k == 36) begin
                s.resetn = 0;
            end else if (k < 18) begin
                s.wen[2] = 1; s.rd[2] = 8; s.ren[1] = 1; s.rs[1] = 8;
            end else begin
                s.id_branch_bp = 1; s.id_pc = 32'(k * 4);
            end
            step();
            e = q.pop_front();
            n_vec++;
            if (dut_ctl !== e.ctl) begin
                n_err++; $display("FAIL sat_%0d ctl act=%h exp=%h", k, dut_ctl, e.ctl);
            end
            n_vec++;
            if ({o_stall_cnt, o_flush_cnt} !== {e.sc, e.fc}) begin
                n_err++; $display("FAIL sat_%0d cnt act=%h/%h exp=%h/%h", k, o_stall_cnt, o_flush_cnt, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            clr();
            case (k)
                0: begin s.mc_issue = 1; s.mc_rd = 9; end
                1: begin s.ren[0] = 1; s.rs[0] = 9; end
                2: begin s.resetn = 0; s.ren[0] = 1; s.rs[0] = 9; end
                default: begin s.ren[0] = 1; s.rs[0] = 9; s.id_is_mc = 1; end
            endcase
            step();
            e = q.pop_front();
            n_vec++;
            if (dut_ctl !== e.ctl) begin
                n_err++; $display("FAIL rmid_%0d ctl act=%h exp=%h", k, dut_ctl, e.ctl);
            end
            n_vec++;
            if ({o_stall_cnt, o_flush_cnt} !== {e.sc, e.fc}) begin
                n_err++; $display("FAIL rmid_%0d cnt act=%h/%h exp=%h/%h", k, o_stall_cnt, o_flush_cnt, e.sc, e.fc);
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_sb = '0; n_sb = '0; m_sc = '0; n_sc = '0; m_fc = '0; n_fc = '0;
        m_known = 1'b0; n_known = 1'b0;
        clr();
        d = s;
        d.resetn = 1'b0;
        test_reset();
        test_forwarding();
        test_scoreboard();
        test_branch();
        test_saturation();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
